// File: rtl/axi_wr_pkg.sv
// Shared AXI write-master constants and FSM encoding.
// Both the write master and its burst-size calculator import this package.
package axi_wr_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K         = 4096;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        AW   = 3'd2,
        W    = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizer: min(beats_left, MAX_BURST, beats remaining before the next 4 KB page).
// Shared by the write master and, later, the read master.
module axi_burst_calc
    import axi_wr_pkg::*;
#(
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int BYTE_SHIFT = 2
) (
    input  logic [LEN_WIDTH-1:0] beats_left,
    input  logic [11:0]          addr_lo,
    output logic [8:0]           burst
);

    // 13 bits hold the full 4096-byte distance when addr_lo is zero.
    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] beats_to_4k;
    logic [CW-1:0] left_w;
    logic [CW-1:0] cap_w;
    logic [CW-1:0] min_w;

    always_comb begin
        bytes_to_4k = 13'(AXI_4K) - {1'b0, addr_lo};
        beats_to_4k = CW'(bytes_to_4k >> BYTE_SHIFT);
        left_w      = CW'(beats_left);
        cap_w       = CW'(MAX_BURST);
        min_w       = (left_w < cap_w) ? left_w : cap_w;
        if (beats_to_4k < min_w) begin
            min_w = beats_to_4k;
        end
        burst = min_w[8:0];
    end

endmodule

// File: rtl/axi_wr_burst_master.sv
// AXI4 write master: splits one command into INCR bursts (<= MAX_BURST, never crossing 4 KB)
// and streams user data onto W, accumulating write-response errors across the command.
module axi_wr_burst_master
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_beats,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    output logic                    done,
    output logic                    err,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_bvalid,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_bready
);

    localparam int                    BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << BYTE_SHIFT) - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [8:0]            burst_q;
    logic [8:0]            burst_calc;
    logic [7:0]            beat_cnt;
    logic                  err_acc;
    logic                  bresp_err;

    axi_burst_calc #(
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .BYTE_SHIFT (BYTE_SHIFT)
    ) u_burst_calc (
        .beats_left (beats_left),
        .addr_lo    (cur_addr[11:0]),
        .burst      (burst_calc)
    );

    // The W channel is a pass-through of the user stream, gated to the W state.
    assign cmd_ready     = (state == IDLE);
    assign axi_wvalid    = (state == W) && wr_data_valid;
    assign axi_wdata     = wr_data;
    assign axi_wlast     = (state == W) && (beat_cnt == 8'd0);
    assign wr_data_ready = axi_wvalid && axi_wready;
    assign axi_awsize    = 3'(BYTE_SHIFT);
    assign axi_awburst   = AXI_BURST_INCR;
    assign axi_wstrb     = '1;
    assign bresp_err     = (axi_bresp != AXI_RESP_OKAY);

    // NOTE: every register here is state, so all updates use non-blocking assignments;
    // reset is synchronous, sampled on the same edge as normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            beats_left  <= '0;
            burst_q     <= '0;
            beat_cnt    <= '0;
            err_acc     <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_bready  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: done/err default low each cycle so they form single-cycle pulses.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr & ALIGN_MASK;
                        beats_left <= cmd_beats;
                        err_acc    <= 1'b0;
                        if (cmd_beats == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    burst_q     <= burst_calc;
                    axi_awaddr  <= cur_addr;
                    axi_awlen   <= 8'(burst_calc - 9'd1);
                    beat_cnt    <= 8'(burst_calc - 9'd1);
                    axi_awvalid <= 1'b1;
                    state       <= AW;
                end
                AW: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        state       <= W;
                    end
                end
                W: begin
                    if (wr_data_valid && axi_wready) begin
                        if (beat_cnt == 8'd0) begin
                            axi_bready <= 1'b1;
                            state      <= B;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        err_acc    <= err_acc | bresp_err;
                        beats_left <= beats_left - LEN_WIDTH'(burst_q);
                        cur_addr   <= cur_addr + (ADDR_WIDTH'(burst_q) << BYTE_SHIFT);
                        // Error bursts do not abort; the command runs to completion.
                        if (beats_left == LEN_WIDTH'(burst_q)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= err_acc | bresp_err;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Self-checking bench for axi_wr_burst_master: table of commands, reactive AXI slave,
// scoreboard queues for AW/W/done, plus hand-written reset and latency sequences.
module tb_axi_wr_burst_master;
    import axi_wr_pkg::*;

    localparam int AW_W = 26;
    localparam int DW   = 32;
    localparam int MB   = 16;
    localparam int LW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW_W-1:0]   cmd_addr;
    logic [LW-1:0]     cmd_beats;
    logic [DW-1:0]     wr_data;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic              done;
    logic              err;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [AW_W-1:0]   axi_awaddr;
    logic [7:0]        axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [DW-1:0]     axi_wdata;
    logic [DW/8-1:0]   axi_wstrb;
    logic              axi_wlast;
    logic              axi_bvalid;
    logic [1:0]        axi_bresp;
    logic              axi_bready;

    always #5 clk = ~clk;

    axi_wr_burst_master #(
        .ADDR_WIDTH (AW_W),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .done          (done),
        .err           (err),
        .axi_awvalid   (axi_awvalid),
        .axi_awready   (axi_awready),
        .axi_awaddr    (axi_awaddr),
        .axi_awlen     (axi_awlen),
        .axi_awsize    (axi_awsize),
        .axi_awburst   (axi_awburst),
        .axi_wvalid    (axi_wvalid),
        .axi_wready    (axi_wready),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wlast     (axi_wlast),
        .axi_bvalid    (axi_bvalid),
        .axi_bresp     (axi_bresp),
        .axi_bready    (axi_bready)
    );

    typedef struct {
        logic [AW_W-1:0] addr;
        logic [LW-1:0]   beats;
        int              aw_delay;
        bit              toggle;
        bit              gaps;
        int              slverr_burst;
        int              exp_bursts;
        bit              exp_err;
    } vec_t;

    typedef struct {
        logic [AW_W-1:0] addr;
        logic [7:0]      len;
    } aw_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    bit      done_q[$];

    int checks   = 0;
    int failures = 0;

    // Slave behaviour, written only by the main sequence.
    int            aw_delay     = 0;
    bit            toggle       = 1'b0;
    bit            gaps         = 1'b0;
    bit            hold_w       = 1'b0;
    int            slverr_burst = -1;
    logic [DW-1:0] data_base    = '0;

    // Observation state, written only by the slave/monitor process.
    int              cyc         = 0;
    int              accept_cyc  = 0;
    int              last_b_cyc  = 0;
    int              aw_seen     = 0;
    int              beats_seen  = 0;
    int              done_cnt    = 0;
    int              src_idx     = 0;
    int              b_idx       = 0;
    int              aw_wait     = 0;
    bit              cmd_is_zero = 1'b0;
    bit              pending_b   = 1'b0;
    bit              prev_awvalid = 1'b0;
    logic [AW_W-1:0] prev_awaddr = '0;
    logic [7:0]      prev_awlen  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reactive slave: drives inputs on the falling edge, samples 1 time unit later.
    initial begin : slave
        w_exp_t  we;
        aw_exp_t ae;
        axi_awready   = 1'b0;
        axi_wready    = 1'b0;
        axi_bvalid    = 1'b0;
        axi_bresp     = 2'b00;
        wr_data_valid = 1'b0;
        wr_data       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            axi_awready   = (aw_wait >= aw_delay);
            axi_wready    = hold_w ? 1'b0 : (toggle ? ~axi_wready : 1'b1);
            wr_data_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data       = data_base + DW'(src_idx);
            axi_bvalid    = pending_b;
            axi_bresp     = (b_idx == slverr_burst) ? 2'b10 : AXI_RESP_OKAY;
            #1;
            if (rst) begin
                pending_b    = 1'b0;
                aw_wait      = 0;
                prev_awvalid = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    accept_cyc  = cyc;
                    cmd_is_zero = (cmd_beats == '0);
                    src_idx     = 0;
                    b_idx       = 0;
                    aw_seen     = 0;
                    beats_seen  = 0;
                end
                if (axi_awvalid && !prev_awvalid) begin
                    if (aw_seen == 0) check("aw_latency_after_cmd", 64'(cyc - accept_cyc), 64'd2);
                    else              check("aw_latency_after_b", 64'(cyc - last_b_cyc), 64'd2);
                end
                if (axi_awvalid && prev_awvalid) begin
                    check("awaddr_stable", 64'(axi_awaddr), 64'(prev_awaddr));
                    check("awlen_stable", 64'(axi_awlen), 64'(prev_awlen));
                end
                if (axi_awvalid) check("aw_w_overlap", 64'(axi_wvalid), 64'd0);
                if (axi_awvalid && axi_awready) begin
                    aw_seen++;
                    aw_wait = 0;
                    check("aw_expected_pending", 64'(aw_q.size() != 0), 64'd1);
                    if (aw_q.size() != 0) begin
                        ae = aw_q.pop_front();
                        check("awaddr", 64'(axi_awaddr), 64'(ae.addr));
                        check("awlen", 64'(axi_awlen), 64'(ae.len));
                        check("awsize", 64'(axi_awsize), 64'd2);
                        check("awburst", 64'(axi_awburst), 64'd1);
                    end
                end else if (axi_awvalid) begin
                    aw_wait++;
                end
                if (axi_wvalid && axi_wready) begin
                    check("wr_data_ready_on_beat", 64'(wr_data_ready), 64'd1);
                    check("wstrb", 64'(axi_wstrb), 64'hF);
                    check("w_expected_pending", 64'(w_q.size() != 0), 64'd1);
                    if (w_q.size() != 0) begin
                        we = w_q.pop_front();
                        check("wdata", 64'(axi_wdata), 64'(we.data));
                        check("wlast", 64'(axi_wlast), 64'(we.last));
                    end
                    beats_seen++;
                    src_idx++;
                    if (axi_wlast) pending_b = 1'b1;
                end else if (wr_data_valid) begin
                    check("not_consumed", 64'(wr_data_ready), 64'd0);
                end
                if (axi_bready) check("b_w_overlap", 64'(axi_wvalid), 64'd0);
                if (axi_bvalid && axi_bready) begin
                    pending_b  = 1'b0;
                    b_idx++;
                    last_b_cyc = cyc;
                end
                if (err && !done) check("err_without_done", 64'(err), 64'd0);
                if (done) begin
                    done_cnt++;
                    if (cmd_is_zero) check("done_latency_zero", 64'(cyc - accept_cyc), 64'd1);
                    else             check("done_latency_after_b", 64'(cyc - last_b_cyc), 64'd1);
                    check("done_expected_pending", 64'(done_q.size() != 0), 64'd1);
                    if (done_q.size() != 0) check("err", 64'(err), 64'(done_q.pop_front()));
                end
                prev_awvalid = axi_awvalid;
                prev_awaddr  = axi_awaddr;
                prev_awlen   = axi_awlen;
            end
        end
    end

    // Reference splitter: fills the AW, W and done scoreboards for one command.
    task automatic push_expected(input vec_t v, input logic [DW-1:0] base);
        logic [AW_W-1:0] addr;
        int              left;
        int              b;
        int              to4k;
        int              n;
        addr = v.addr & ~26'h3;
        left = int'(v.beats);
        n    = 0;
        while (left > 0) begin
            to4k = (4096 - int'(addr[11:0])) / 4;
            b    = left;
            if (b > MB)   b = MB;
            if (b > to4k) b = to4k;
            aw_q.push_back('{addr, 8'(b - 1)});
            for (int k = 0; k < b; k++) begin
                w_q.push_back('{base + DW'(n), (k == b - 1)});
                n++;
            end
            addr = addr + AW_W'(b * 4);
            left -= b;
        end
        done_q.push_back(v.exp_err);
    endtask

    task automatic issue_cmd(input logic [AW_W-1:0] addr, input logic [LW-1:0] beats);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_addr  = addr;
        cmd_beats = beats;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int n0;
        data_base    = {8'(idx + 1), 24'h00A500};
        aw_delay     = v.aw_delay;
        toggle       = v.toggle;
        gaps         = v.gaps;
        slverr_burst = v.slverr_burst;
        push_expected(v, data_base);
        n0 = done_cnt;
        issue_cmd(v.addr, v.beats);
        for (int c = 0; c < 3000 && done_cnt == n0; c++) @(negedge clk);
        #2;
        check($sformatf("v%0d_done_seen", idx), 64'(done_cnt != n0), 64'd1);
        check($sformatf("v%0d_bursts", idx), 64'(aw_seen), 64'(v.exp_bursts));
        check($sformatf("v%0d_beats", idx), 64'(beats_seen), 64'(v.beats));
        check($sformatf("v%0d_aw_q_empty", idx), 64'(aw_q.size()), 64'd0);
        check($sformatf("v%0d_w_q_empty", idx), 64'(w_q.size()), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin : main
        int waited;
        vecs[0] = '{26'h0000100, 16'd16, 0, 1'b0, 1'b0, -1, 1, 1'b0};
        vecs[1] = '{26'h0000000, 16'd40, 0, 1'b0, 1'b0, -1, 3, 1'b0};
        vecs[2] = '{26'h0000FF8, 16'd6,  0, 1'b0, 1'b0, -1, 2, 1'b0};
        vecs[3] = '{26'h00003C0, 16'd20, 5, 1'b1, 1'b1, -1, 2, 1'b0};
        vecs[4] = '{26'h0001000, 16'd48, 0, 1'b0, 1'b0,  1, 3, 1'b1};
        vecs[5] = '{26'h0002000, 16'd5,  0, 1'b0, 1'b0, -1, 1, 1'b0};
        vecs[6] = '{26'h0000103, 16'd3,  0, 1'b0, 1'b0, -1, 1, 1'b0};
        vecs[7] = '{26'h3FFFFF8, 16'd4,  0, 1'b0, 1'b0, -1, 2, 1'b0};
        vecs[8] = '{26'h0000040, 16'd0,  0, 1'b0, 1'b0, -1, 0, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_awvalid", 64'(axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(axi_wvalid), 64'd0);
        check("rst_bready", 64'(axi_bready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_wr_data_ready", 64'(wr_data_ready), 64'd0);
        check("rst_awaddr", 64'(axi_awaddr), 64'd0);
        check("rst_awlen", 64'(axi_awlen), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

        // Reset in the middle of W: slave withholds wready so the master parks in W.
        hold_w       = 1'b1;
        aw_delay     = 0;
        toggle       = 1'b0;
        gaps         = 1'b0;
        slverr_burst = -1;
        aw_q.push_back('{26'h0000500, 8'd15});
        issue_cmd(26'h0000500, 16'd16);
        waited = 0;
        while (aw_seen == 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #2;
        check("midw_aw_done", 64'(aw_seen), 64'd1);
        check("midw_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        check("midw_wvalid", 64'(axi_wvalid), 64'd1);
        check("midw_no_consume_without_wready", 64'(wr_data_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midw_rst_awvalid", 64'(axi_awvalid), 64'd0);
        check("midw_rst_wvalid", 64'(axi_wvalid), 64'd0);
        check("midw_rst_wlast", 64'(axi_wlast), 64'd0);
        check("midw_rst_bready", 64'(axi_bready), 64'd0);
        check("midw_rst_done", 64'(done), 64'd0);
        check("midw_rst_err", 64'(err), 64'd0);
        check("midw_rst_wr_data_ready", 64'(wr_data_ready), 64'd0);
        check("midw_rst_awaddr", 64'(axi_awaddr), 64'd0);
        check("midw_rst_awlen", 64'(axi_awlen), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        hold_w = 1'b0;
        w_q.delete();
        aw_q.delete();
        @(negedge clk);
        #2;
        check("midw_cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        // A clean command after the abandoned one completes normally.
        run_cmd(vecs[5], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
